// File: rtl/mux_n_w_pack_if.sv
// Narrow-to-wide packer bus: input beat handshake plus packed-word output handshake.
// MUX_PACK_PARITY_EN adds the per-lane parity_out signal.
interface mux_n_w_pack_if #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned RATIO = 4
);
    localparam int unsigned OUT_W = IN_W * RATIO;
    localparam int unsigned CNT_W = $clog2(RATIO + 1);

    logic [IN_W-1:0]  data_in;
    logic             valid_in;
    logic             last_in;
    logic             ready_in;
    logic [OUT_W-1:0] data_out;
    logic             valid_out;
    logic             ready_out;
    logic             last_out;
    logic [CNT_W-1:0] beats_out;
`ifdef MUX_PACK_PARITY_EN
    logic [RATIO-1:0] parity_out;

    modport master (
        output data_in, valid_in, last_in, ready_out,
        input  ready_in, data_out, valid_out, last_out, beats_out, parity_out
    );
    modport slave (
        input  data_in, valid_in, last_in, ready_out,
        output ready_in, data_out, valid_out, last_out, beats_out, parity_out
    );
`else
    modport master (
        output data_in, valid_in, last_in, ready_out,
        input  ready_in, data_out, valid_out, last_out, beats_out
    );
    modport slave (
        input  data_in, valid_in, last_in, ready_out,
        output ready_in, data_out, valid_out, last_out, beats_out
    );
`endif
endinterface

// File: rtl/mux_n_w_pack.sv
// Packs RATIO beats of IN_W bits into one MSB-first word, with frame-end flush and a beat count.
// Optional feature: MUX_PACK_PARITY_EN adds a registered per-lane parity output.
module mux_n_w_pack #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned RATIO = 4
) (
    input logic           clk_4f,
    input logic           reset,
    mux_n_w_pack_if.slave bus
);
    localparam int unsigned OUT_W = IN_W * RATIO;
    localparam int unsigned CNT_W = $clog2(RATIO + 1);
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(RATIO - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] beats_q, beats_d;
    logic [OUT_W-1:0] merged;
    logic             ready;
    logic             accept;
    logic             emit;

    assign ready  = !valid_q | bus.ready_out;
    assign accept = bus.valid_in & ready;
    assign emit   = accept & ((cnt_q == LastCnt) | bus.last_in);

    // Lanes above the current beat are forced to zero so a flushed word is zero-padded.
    always_comb begin
        merged = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (CNT_W'(i) < cnt_q) begin
                merged[OUT_W-1-i*IN_W -: IN_W] = acc_q[OUT_W-1-i*IN_W -: IN_W];
            end else if (CNT_W'(i) == cnt_q) begin
                merged[OUT_W-1-i*IN_W -: IN_W] = bus.data_in;
            end
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        beats_d = beats_q;
        if (valid_q && bus.ready_out) begin
            valid_d = 1'b0;
        end
        if (emit) begin
            cnt_d   = '0;
            acc_d   = '0;
            data_d  = merged;
            valid_d = 1'b1;
            last_d  = bus.last_in;
            beats_d = cnt_q + CNT_W'(1);
        end else if (accept) begin
            cnt_d = cnt_q + CNT_W'(1);
            acc_d = merged;
        end
    end

    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            beats_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            beats_q <= beats_d;
        end
    end

    assign bus.ready_in  = ready;
    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.last_out  = last_q;
    assign bus.beats_out = beats_q;

`ifdef MUX_PACK_PARITY_EN
    logic [RATIO-1:0] parity_q, parity_d;

    // Parity bits are MSB-aligned like the data: the top bit belongs to the first lane.
    always_comb begin
        parity_d = parity_q;
        if (emit) begin
            for (int unsigned i = 0; i < RATIO; i++) begin
                parity_d[RATIO-1-i] = ^merged[OUT_W-1-i*IN_W -: IN_W];
            end
        end
    end

    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            parity_q <= '0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign bus.parity_out = parity_q;
`endif
endmodule

// File: tb/tb_mux_n_w_pack.sv
// Bench for mux_n_w_pack: directed cases with literal expectations, then random traffic,
// all checked every cycle against a queue-based reference model (8x4 and 4x1 instances).
module tb_mux_n_w_pack;
    logic clk_4f = 1'b0;
    logic reset  = 1'b0;
    int   vectors    = 0;
    int   miscompares = 0;

    always #5 clk_4f = ~clk_4f;

    mux_n_w_pack_if #(.IN_W(8), .RATIO(4)) bus_a ();
    mux_n_w_pack_if #(.IN_W(4), .RATIO(1)) bus_b ();

    mux_n_w_pack #(.IN_W(8), .RATIO(4)) dut_a (.clk_4f(clk_4f), .reset(reset), .bus(bus_a));
    mux_n_w_pack #(.IN_W(4), .RATIO(1)) dut_b (.clk_4f(clk_4f), .reset(reset), .bus(bus_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected output register contents and beats collected so far.
    logic [31:0] ma_data;
    logic        ma_valid, ma_last;
    logic [2:0]  ma_beats;
    logic [3:0]  ma_par;
    logic [7:0]  ma_part[$];
    logic [3:0]  mb_data;
    logic        mb_valid, mb_last;

    task automatic model_clear();
        ma_data = '0; ma_valid = 0; ma_last = 0; ma_beats = '0; ma_par = '0;
        ma_part.delete();
        mb_data = '0; mb_valid = 0; mb_last = 0;
    endtask

    task automatic model_step();
        logic [31:0] w;
        logic [3:0]  p;
        logic        acc_a, acc_b;
        acc_a = bus_a.valid_in && (!ma_valid || bus_a.ready_out);
        acc_b = bus_b.valid_in && (!mb_valid || bus_b.ready_out);
        if (ma_valid && bus_a.ready_out) ma_valid = 0;
        if (mb_valid && bus_b.ready_out) mb_valid = 0;
        if (acc_a) begin
            ma_part.push_back(bus_a.data_in);
            if (ma_part.size() == 4 || bus_a.last_in) begin
                w = '0;
                p = '0;
                foreach (ma_part[k]) begin
                    w[31-8*k -: 8] = ma_part[k];
                    p[3-k]         = ^ma_part[k];
                end
                ma_data = w; ma_par = p; ma_valid = 1; ma_last = bus_a.last_in;
                ma_beats = 3'(ma_part.size());
                ma_part.delete();
            end
        end
        if (acc_b) begin
            mb_data = bus_b.data_in; mb_valid = 1; mb_last = bus_b.last_in;
        end
    endtask

    // Single compare process: outputs just after each edge, ready_in mid-cycle.
    initial begin
        model_clear();
        forever begin
            @(posedge clk_4f);
            if (!reset) model_clear();
            else model_step();
            #1;
            if (!reset) model_clear();
            chk("a_valid_out", 32'(bus_a.valid_out), 32'(ma_valid));
            if (ma_valid || !reset) begin
                chk("a_data_out", bus_a.data_out, ma_data);
                chk("a_last_out", 32'(bus_a.last_out), 32'(ma_last));
                chk("a_beats_out", 32'(bus_a.beats_out), 32'(ma_beats));
`ifdef MUX_PACK_PARITY_EN
                chk("a_parity_out", 32'(bus_a.parity_out), 32'(ma_par));
`endif
            end
            chk("b_valid_out", 32'(bus_b.valid_out), 32'(mb_valid));
            if (mb_valid || !reset) begin
                chk("b_data_out", 32'(bus_b.data_out), 32'(mb_data));
                chk("b_last_out", 32'(bus_b.last_out), 32'(mb_last));
                chk("b_beats_out", 32'(bus_b.beats_out), (!reset) ? 32'd0 : 32'd1);
            end
            @(negedge clk_4f);
            #2;
            if (!reset) model_clear();
            chk("a_ready_in", 32'(bus_a.ready_in), 32'(!ma_valid || bus_a.ready_out));
            chk("b_ready_in", 32'(bus_b.ready_in), 32'(!mb_valid || bus_b.ready_out));
        end
    end

    // Hold a beat until accepted; returns just after the accepting edge.
    task automatic send_a(input logic [7:0] d, input logic l);
        int  n;
        logic took;
        n = 0;
        took = 0;
        @(negedge clk_4f);
        bus_a.valid_in = 1; bus_a.data_in = d; bus_a.last_in = l;
        while (!took) begin
            #1 took = bus_a.ready_in;
            @(posedge clk_4f);
            if (!took) begin
                n++;
                if (n > 50) begin
                    chk("send_a_timeout", 32'd0, 32'd1);
                    break;
                end
                @(negedge clk_4f);
            end
        end
    endtask

    task automatic idle_a();
        @(negedge clk_4f);
        bus_a.valid_in = 0; bus_a.last_in = 0;
    endtask

    initial begin
        bus_a.valid_in = 0; bus_a.data_in = '0; bus_a.last_in = 0; bus_a.ready_out = 1;
        bus_b.valid_in = 0; bus_b.data_in = '0; bus_b.last_in = 0; bus_b.ready_out = 1;
        #3;
        chk("reset_valid", 32'(bus_a.valid_out), 32'd0);
        chk("reset_data", bus_a.data_out, 32'd0);
        repeat (2) @(negedge clk_4f);
        reset = 1;
        #1 chk("ready_after_reset", 32'(bus_a.ready_in), 32'd1);

        // Full word, no stall.
        send_a(8'hA1, 0); send_a(8'hB2, 0); send_a(8'hC3, 0); send_a(8'hD4, 0);
        #1;
        chk("t1_data", bus_a.data_out, 32'hA1B2C3D4);
        chk("t1_beats", 32'(bus_a.beats_out), 32'd4);
        chk("t1_last", 32'(bus_a.last_out), 32'd0);

        // Frame-end flush of two beats.
        send_a(8'h11, 0); send_a(8'h22, 1);
        #1;
        chk("t2_data", bus_a.data_out, 32'h11220000);
        chk("t2_beats", 32'(bus_a.beats_out), 32'd2);
        chk("t2_last", 32'(bus_a.last_out), 32'd1);

        // Back-pressure while a word is pending.
        idle_a();
        @(negedge clk_4f);
        bus_a.ready_out = 0;
        send_a(8'h31, 0); send_a(8'h32, 0); send_a(8'h33, 0); send_a(8'h34, 0);
        #1 chk("t3_word1", bus_a.data_out, 32'h31323334);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_4f);
            bus_a.valid_in = 1; bus_a.data_in = 8'hE0 + 8'(i); bus_a.last_in = 0;
            #1 chk("t3_stall_ready", 32'(bus_a.ready_in), 32'd0);
            @(posedge clk_4f);
            #1 chk("t3_stable", bus_a.data_out, 32'h31323334);
        end
        @(negedge clk_4f);
        bus_a.valid_in = 0;
        bus_a.ready_out = 1;
        send_a(8'h41, 0); send_a(8'h42, 0); send_a(8'h43, 1);
        #1;
        chk("t3_word2", bus_a.data_out, 32'h41424300);
        chk("t3_beats", 32'(bus_a.beats_out), 32'd3);

        // Reset mid-word discards the partial word.
        send_a(8'h51, 0); send_a(8'h52, 0); send_a(8'h53, 0);
        idle_a();
        #3 reset = 0;
        #1;
        chk("t4_valid", 32'(bus_a.valid_out), 32'd0);
        chk("t4_data", bus_a.data_out, 32'd0);
        chk("t4_beats", 32'(bus_a.beats_out), 32'd0);
        repeat (2) @(negedge clk_4f);
        reset = 1;
        send_a(8'h01, 0); send_a(8'h02, 0); send_a(8'h03, 0); send_a(8'h04, 0);
        #1;
        chk("t4_data_after", bus_a.data_out, 32'h01020304);
        chk("t4_beats_after", 32'(bus_a.beats_out), 32'd4);
        idle_a();

        // RATIO=1 pass-through.
        @(negedge clk_4f);
        bus_b.valid_in = 1; bus_b.data_in = 4'h5;
        @(posedge clk_4f);
        #1 chk("t5_word0", 32'(bus_b.data_out), 32'h5);
        @(negedge clk_4f);
        bus_b.data_in = 4'hA;
        @(posedge clk_4f);
        #1;
        chk("t5_word1", 32'(bus_b.data_out), 32'hA);
        chk("t5_beats", 32'(bus_b.beats_out), 32'd1);
        @(negedge clk_4f);
        bus_b.valid_in = 0;

`ifdef MUX_PACK_PARITY_EN
        send_a(8'h01, 0); send_a(8'h03, 1);
        #1;
        chk("t6_parity", 32'(bus_a.parity_out), 32'b1000);
        chk("t6_beats", 32'(bus_a.beats_out), 32'd2);
        idle_a();
`endif

        // Random traffic on both instances, with one asynchronous reset mid-stream.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_4f);
            bus_a.valid_in  = ($urandom_range(3) != 0);
            bus_a.data_in   = 8'($urandom);
            bus_a.last_in   = ($urandom_range(5) == 0);
            bus_a.ready_out = ($urandom_range(3) != 0);
            bus_b.valid_in  = ($urandom_range(1) != 0);
            bus_b.data_in   = 4'($urandom);
            bus_b.last_in   = ($urandom_range(3) == 0);
            bus_b.ready_out = ($urandom_range(2) != 0);
            if (i == 1500) begin
                #3 reset = 0;
                @(negedge clk_4f);
                reset = 1;
            end
        end
        @(negedge clk_4f);
        bus_a.valid_in = 0; bus_b.valid_in = 0;
        repeat (3) @(negedge clk_4f);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
